iceram_param: RTL and testbench
===============================

ICERAM_PARAM -- requirements
Module: iceram_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (1..64).
REQ-002 SHALL have parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter OUT_REG, default 0, adding one output register stage when 1.
REQ-004 SHALL have parameter CLEAR_ON_RST, default 1, enabling the post-reset zero-fill sequencer when 1.
REQ-005 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port WADDR  input  ADDR_W  write address.
REQ-008 SHALL have port WDATA  input  WIDTH  write data.
REQ-009 SHALL have port MASK  input  WIDTH  per-bit write mask; 1 = bit not written.
REQ-010 SHALL have port WE  input  1  write request.
REQ-011 SHALL have port RADDR  input  ADDR_W  read address.
REQ-012 SHALL have port RE  input  1  read request.
REQ-013 SHALL have port RDATA  output  WIDTH  read data.
REQ-014 SHALL have port RVALID  output  1  one-cycle pulse marking new RDATA.
REQ-015 SHALL have port BUSY  output  1  high while zero-fill runs; requests ignored.

Function
REQ-016 SHALL implement FSM states CLEAR and RUN; after reset, state = CLEAR if CLEAR_ON_RST=1, else RUN.
REQ-017 In CLEAR, SHALL write all-zero to address CNT each cycle, CNT incrementing 0..DEPTH-1; transition to RUN on the cycle writing DEPTH-1.
REQ-018 Zero-fill SHALL take exactly DEPTH cycles from the first CLK edge after RST falls; BUSY falls with the RUN transition.
REQ-019 While BUSY=1, WE and RE SHALL be ignored: no array write from port, RVALID=0, RDATA held.
REQ-020 In RUN, a CLK edge with WE=1 SHALL set mem[WADDR][i] = WDATA[i] for every i with MASK[i]=0, leaving others unchanged.
REQ-021 In RUN, a CLK edge N with RE=1 SHALL present mem[RADDR] on RDATA after edge N (OUT_REG=0) or after edge N+1 (OUT_REG=1), with RVALID=1 for exactly that cycle.
REQ-022 Back-to-back RE SHALL sustain one read per cycle at full throughput in both OUT_REG modes.
REQ-023 With RE=0, RDATA SHALL hold its last value and RVALID SHALL be 0 (after pipeline drain).
REQ-024 Simultaneous read and write to the same address SHALL return the pre-write data (read-before-write); write still completes.
REQ-025 Simultaneous read and write to different addresses SHALL be independent.
REQ-026 With CLEAR_ON_RST=0, array contents after reset SHALL be undefined (X in simulation) and BUSY constantly 0 outside reset.

Reset
REQ-027 RST assertion SHALL immediately force RDATA=0, RVALID=0, CNT=0, pipeline stage cleared, BUSY=CLEAR_ON_RST.
REQ-028 RST asserted mid-CLEAR SHALL abort and, on release, restart zero-fill at address 0.
REQ-029 RST SHALL NOT reset the memory array directly; only the zero-fill sequencer clears it.

Structure
REQ-030 FSM state encoding (CLEAR, RUN) SHALL reside in shared package iceram_pkg.
REQ-031 The zero-fill counter and FSM SHALL be sub-module iceram_clr (ports CLK, RST, BUSY, CNT); array and read pipeline remain in iceram_param.
REQ-032 The array SHALL be inferable as iCE40 block RAM (registered read address, no async read path).

Verification
REQ-033 WIDTH=32, ADDR_W=8, CLEAR_ON_RST=1: release RST -> BUSY=1 for exactly 256 cycles; then read all addresses -> every word 0x00000000.
REQ-034 Write 0xFFFFFFFF to addr 0x10 with MASK=0x0000FFFF over 0x12345678 -> read returns 0xFFFF5678.
REQ-035 Same cycle WE to 0x20 (data 0xA5A5A5A5, old 0x11111111) and RE at 0x20 -> RDATA=0x11111111; next read returns 0xA5A5A5A5.
REQ-036 OUT_REG=1, RE at edges N..N+3 over addrs 0..3 -> RVALID high edges N+1..N+4 carrying words 0..3 in order.
REQ-037 Assert RST at clear count 100, release -> BUSY stays high another full 256 cycles; WE/RE during BUSY have no effect (RVALID=0, written value absent afterwards).
REQ-038 WIDTH=16, ADDR_W=4, CLEAR_ON_RST=0 -> BUSY=0 immediately after reset; write/read of 0xBEEF at addr 0xF returns 0xBEEF with one-cycle latency.

Source files
------------

// File: rtl/iceram_pkg.sv
// Shared definitions for the iceram block RAM wrapper.
// Holds the zero-fill sequencer state encoding used by iceram_clr.
// No logic lives here, only types.
package iceram_pkg;

  // Sequencer states: CLEAR while zero-filling the array, RUN for normal access.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_t;

endpackage

// File: rtl/iceram_clr.sv
// Post-reset zero-fill sequencer: walks CNT over every address while BUSY.
// Latency: leaves CLEAR on the edge that writes the last address (2**ADDR_W edges).
// Backpressure: none; BUSY tells the parent to ignore port requests.
module iceram_clr
  import iceram_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              BUSY,
  output logic [ADDR_W-1:0] CNT
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_t        state;
  clr_state_t        state_nxt;
  logic [ADDR_W-1:0] cnt_nxt;

  // State and address counter; reset restarts the fill from address 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      if (CLEAR_ON_RST != 0) begin
        state <= ST_CLEAR;
      end else begin
        state <= ST_RUN;
      end
      CNT <= '0;
    end else begin
      state <= state_nxt;
      CNT   <= cnt_nxt;
    end
  end

  // Next state: step through every address once, then hand over to RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = CNT;
    BUSY      = 1'b0;
    case (state)
      ST_CLEAR: begin
        BUSY    = 1'b1;
        cnt_nxt = CNT + 1'b1;
        if (CNT == LAST_ADDR) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_nxt = CNT;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

endmodule

// File: rtl/iceram_param.sv
// Parameterised single-port-write / single-port-read RAM with bit mask and optional zero-fill.
// Latency: read data one edge after RE (OUT_REG=0) or two edges (OUT_REG=1), one read per cycle.
// Backpressure: none; requests are dropped while BUSY is high.
module iceram_param
  import iceram_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int ADDR_W       = 8,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [WIDTH-1:0]  WDATA,
  input  logic [WIDTH-1:0]  MASK,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RADDR,
  input  logic              RE,
  output logic [WIDTH-1:0]  RDATA,
  output logic              RVALID,
  output logic              BUSY
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              busy;
  logic [ADDR_W-1:0] cnt;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_dat;
  logic [WIDTH-1:0]  wr_keep;
  logic              rd_en;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_q;
  logic              rd_vld;

  iceram_clr #(
    .ADDR_W       (ADDR_W),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clr (
    .CLK  (CLK),
    .RST  (RST),
    .BUSY (busy),
    .CNT  (cnt)
  );

  assign BUSY = busy;

  // Write port source: the sequencer owns it during fill, the user port afterwards.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = WADDR;
    wr_dat  = WDATA;
    wr_keep = MASK;
    rd_en   = 1'b0;
    if (!RST) begin
      if (busy) begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_dat  = '0;
        wr_keep = '0;
      end else begin
        wr_en   = WE;
        rd_en   = RE;
      end
    end
  end

  // Array with per-bit write enable and synchronous read; the read sees pre-write data.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!wr_keep[i]) begin
          mem[wr_addr][i] <= wr_dat[i];
        end
      end
    end
    if (rd_en) begin
      rd_q <= mem[RADDR];
    end
  end

  // Marks the cycle in which the array output carries a fresh word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_en;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] out_q;
      logic             out_vld;

      // Extra output stage; captures only fresh array words so RDATA holds otherwise.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          out_q   <= '0;
          out_vld <= 1'b0;
        end else begin
          out_vld <= rd_vld;
          if (rd_vld) begin
            out_q <= rd_q;
          end
        end
      end

      assign RDATA  = out_q;
      assign RVALID = out_vld;
    end else begin : g_out_direct
      logic rd_seen;

      // The array register has no reset, so RDATA is forced to zero until the first read.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          rd_seen <= 1'b0;
        end else if (rd_en) begin
          rd_seen <= 1'b1;
        end
      end

      assign RDATA  = rd_seen ? rd_q : '0;
      assign RVALID = rd_vld;
    end
  endgenerate

endmodule

// File: tb/tb_iceram_param.sv
// Self-checking bench for iceram_param: three configurations share one stimulus stream.
// A: 32x256 direct output with fill, B: same with output register, C: 16x16 without fill.
// Expected values come from an array-level model updated once per clock edge.
module tb_iceram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we, re;
  logic [7:0]  waddr, raddr;
  logic [31:0] wdata, mask;

  logic [31:0] rdata_a, rdata_b;
  logic [15:0] rdata_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic        busy_a, busy_b, busy_c;

  iceram_param #(.WIDTH(32), .ADDR_W(8), .OUT_REG(0), .CLEAR_ON_RST(1)) dut_a (
    .CLK(clk), .RST(rst), .WADDR(waddr), .WDATA(wdata), .MASK(mask), .WE(we),
    .RADDR(raddr), .RE(re), .RDATA(rdata_a), .RVALID(rvalid_a), .BUSY(busy_a));

  iceram_param #(.WIDTH(32), .ADDR_W(8), .OUT_REG(1), .CLEAR_ON_RST(1)) dut_b (
    .CLK(clk), .RST(rst), .WADDR(waddr), .WDATA(wdata), .MASK(mask), .WE(we),
    .RADDR(raddr), .RE(re), .RDATA(rdata_b), .RVALID(rvalid_b), .BUSY(busy_b));

  iceram_param #(.WIDTH(16), .ADDR_W(4), .OUT_REG(0), .CLEAR_ON_RST(0)) dut_c (
    .CLK(clk), .RST(rst), .WADDR(waddr[3:0]), .WDATA(wdata[15:0]), .MASK(mask[15:0]), .WE(we),
    .RADDR(raddr[3:0]), .RE(re), .RDATA(rdata_c), .RVALID(rvalid_c), .BUSY(busy_c));

  // Reference model state
  logic [31:0] m_mem [256];
  int          remaining;
  logic        a_vld, b_vld;
  logic [31:0] a_dat, b_dat;
  logic [15:0] c_mem [16];
  bit          c_kn  [16];
  logic        c_vld;
  logic [15:0] c_dat;
  bit          c_dat_kn;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic w, input logic [7:0] wa, input logic [31:0] wd,
                        input logic [31:0] mk, input logic r, input logic [7:0] ra);
    we = w; waddr = wa; wdata = wd; mask = mk; re = r; raddr = ra;
  endtask

  task automatic rand_in();
    int mk_sel;
    we    = 1'($urandom_range(0, 1));
    re    = 1'($urandom_range(0, 1));
    waddr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
    raddr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
    wdata = $urandom;
    mk_sel = $urandom_range(0, 3);
    mask  = (mk_sel == 0) ? 32'h0 : (mk_sel == 1) ? 32'hFFFF_FFFF : $urandom;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [31:0] mk);
    return (old & mk) | (nw & ~mk);
  endfunction

  task automatic model_reset();
    a_vld = 1'b0; a_dat = '0;
    b_vld = 1'b0; b_dat = '0;
    c_vld = 1'b0; c_dat = '0; c_dat_kn = 1'b1;
    remaining = 256;
  endtask

  // One rising edge of the behavioural model.
  task automatic model_edge();
    if (rst) return;
    // Output-register copy sees last cycle's array output.
    b_vld = a_vld;
    if (a_vld) b_dat = a_dat;
    if (remaining > 0) begin
      m_mem[256 - remaining] = '0;
      remaining--;
      a_vld = 1'b0;
    end else begin
      a_vld = re;
      if (re) a_dat = m_mem[raddr];
      if (we) m_mem[waddr] = merge(m_mem[waddr], wdata, mask);
    end
    // Configuration C never fills and is never busy.
    c_vld = re;
    if (re) begin
      c_dat    = c_mem[raddr[3:0]];
      c_dat_kn = c_kn[raddr[3:0]];
    end
    if (we) begin
      if (c_kn[waddr[3:0]]) begin
        c_mem[waddr[3:0]] = 16'(merge({16'h0, c_mem[waddr[3:0]]}, wdata, mask));
      end else if (mask[15:0] == 16'h0) begin
        c_mem[waddr[3:0]] = wdata[15:0];
        c_kn[waddr[3:0]]  = 1'b1;
      end
    end
  endtask

  task automatic compare();
    check("busy_a",   64'(busy_a),   64'(remaining > 0));
    check("busy_b",   64'(busy_b),   64'(remaining > 0));
    check("busy_c",   64'(busy_c),   64'(0));
    check("rvalid_a", 64'(rvalid_a), 64'(a_vld));
    check("rdata_a",  64'(rdata_a),  64'(a_dat));
    check("rvalid_b", 64'(rvalid_b), 64'(b_vld));
    check("rdata_b",  64'(rdata_b),  64'(b_dat));
    check("rvalid_c", 64'(rvalid_c), 64'(c_vld));
    if (c_dat_kn) check("rdata_c", 64'(rdata_c), 64'(c_dat));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    model_reset();
    #1;
    compare();
    repeat (hold) step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    for (int i = 0; i < 16; i++) begin
      c_mem[i] = '0;
      c_kn[i]  = 1'b0;
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    do_reset(2);

    // Let the fill run to count 100, then abort with reset.
    for (int i = 0; i < 100; i++) begin
      rand_in();
      step();
    end
    do_reset(2);

    // Full fill after the abort; requests during it must be ignored.
    n = 0;
    while (busy_a && n < 400) begin
      rand_in();
      if (n == 200) set_in(1, 8'd5, 32'hDEAD_BEEF, 32'h0, 1, 8'd5);
      step();
      n++;
    end
    check("busy_len", 64'(n), 64'(256));

    // Sweep every address back-to-back: all words read as zero.
    for (int i = 0; i < 256; i++) begin
      set_in(0, 0, 0, 0, 1, 8'(i));
      step();
    end
    check("sweep_last", 64'(rdata_a), 64'(0));
    set_in(0, 0, 0, 0, 1, 8'd5);
    step();
    check("busy_write_absent", 64'(rdata_a), 64'(0));

    // Masked write merges into the old word.
    set_in(1, 8'h10, 32'h1234_5678, 32'h0, 0, 0);
    step();
    set_in(1, 8'h10, 32'hFFFF_FFFF, 32'h0000_FFFF, 0, 0);
    step();
    set_in(0, 0, 0, 0, 1, 8'h10);
    step();
    check("mask_merge", 64'(rdata_a), 64'(32'hFFFF_5678));

    // Same-address read and write returns the old word first.
    set_in(1, 8'h20, 32'h1111_1111, 32'h0, 0, 0);
    step();
    set_in(1, 8'h20, 32'hA5A5_A5A5, 32'h0, 1, 8'h20);
    step();
    check("rbw_old", 64'(rdata_a), 64'(32'h1111_1111));
    set_in(0, 0, 0, 0, 1, 8'h20);
    step();
    check("rbw_new", 64'(rdata_a), 64'(32'hA5A5_A5A5));

    // Registered output: four back-to-back reads emerge one edge later, in order.
    for (int i = 0; i < 4; i++) begin
      set_in(1, 8'(i), 32'h100 + 32'(i), 32'h0, 0, 0);
      step();
    end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) set_in(0, 0, 0, 0, 1, 8'(k));
      else       set_in(0, 0, 0, 0, 0, 0);
      step();
      if (k == 0) begin
        check("oreg_vld0", 64'(rvalid_b), 64'(0));
      end else begin
        check("oreg_vld", 64'(rvalid_b), 64'(1));
        check("oreg_dat", 64'(rdata_b), 64'(32'h100 + 32'(k - 1)));
      end
    end

    // No-fill configuration: write then read of the top address.
    set_in(1, 8'h0F, 32'h0000_BEEF, 32'h0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 1, 8'h0F);
    step();
    check("nofill_dat", 64'(rdata_c), 64'(16'hBEEF));
    check("nofill_vld", 64'(rvalid_c), 64'(1));

    // Random traffic, then idle to confirm hold behaviour.
    for (int i = 0; i < 2000; i++) begin
      rand_in();
      step();
    end
    set_in(0, 0, 0, 0, 0, 0);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
